// File: rtl/ysyx_23060187_mem_arbiter.sv
// Round-robin arbiter giving the IFU (m0) and the LSU (m1) turns on the single data-memory port.
// Only one transaction is in flight at a time, and a slave that never answers gets an error response after TIMEOUT cycles.
module ysyx_23060187_mem_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic              m0_resp_valid,
  input  logic              m0_resp_ready,
  output logic [31:0]       m0_rdata,
  output logic              m0_err,

  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_wen,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wmask,
  output logic              m1_resp_valid,
  input  logic              m1_resp_ready,
  output logic [31:0]       m1_rdata,
  output logic              m1_err,

  output logic              s_req_valid,
  input  logic              s_req_ready,
  output logic [ADDR_W-1:0] s_addr,
  output logic              s_wen,
  output logic [31:0]       s_wdata,
  output logic [3:0]        s_wmask,
  input  logic              s_resp_valid,
  output logic              s_resp_ready,
  input  logic [31:0]       s_rdata
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;
  localparam int unsigned CNT_W  = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } req_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SREQ      = 2'd1,
    WAIT_RESP = 2'd2,
    MRESP     = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic              grant, last_grant;
  logic              grant_nxt;
  logic              accept;
  logic              resp_ack;
  logic              timeout;
  logic [CNT_W-1:0]  cnt;
  req_t              req_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  // When both masters request, grant the one that did not win last time.
  always_comb begin
    grant_nxt = 1'b0;
    if (m0_req_valid && m1_req_valid) begin
      grant_nxt = ~last_grant;
    end else if (m1_req_valid) begin
      grant_nxt = 1'b1;
    end
  end

  assign timeout  = (cnt == CNT_LAST);
  assign resp_ack = grant ? m1_resp_ready : m0_resp_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    m0_req_ready  = 1'b0;
    m1_req_ready  = 1'b0;
    s_req_valid   = 1'b0;
    s_resp_ready  = 1'b0;
    m0_resp_valid = 1'b0;
    m1_resp_valid = 1'b0;
    case (state)
      IDLE: begin
        // Any late s_resp_valid from an abandoned (timed-out) transaction is swallowed here.
        s_resp_ready = 1'b1;
        if (rst && (m0_req_valid || m1_req_valid)) begin
          accept       = 1'b1;
          m0_req_ready = ~grant_nxt;
          m1_req_ready = grant_nxt;
          state_nxt    = SREQ;
        end
      end
      SREQ: begin
        s_req_valid = 1'b1;
        if (s_req_ready) state_nxt = WAIT_RESP;
      end
      WAIT_RESP: begin
        s_resp_ready = 1'b1;
        if (s_resp_valid || timeout) state_nxt = MRESP;
      end
      MRESP: begin
        m0_resp_valid = ~grant;
        m1_resp_valid = grant;
        if (resp_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latched request and response, plus the WAIT_RESP timeout counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      req_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        grant      <= grant_nxt;
        last_grant <= grant_nxt;
        if (grant_nxt) begin
          req_q.addr  <= m1_addr;
          req_q.wen   <= m1_wen;
          req_q.wdata <= m1_wdata;
          req_q.wmask <= m1_wmask;
        end else begin
          req_q.addr  <= m0_addr;
          req_q.wen   <= 1'b0;
          req_q.wdata <= '0;
          req_q.wmask <= '0;
        end
      end
      if (state == SREQ && s_req_ready) begin
        cnt <= '0;
      end
      if (state == WAIT_RESP) begin
        // A real response in the same cycle as the limit takes priority over the error.
        if (s_resp_valid) begin
          rdata_q <= s_rdata;
          err_q   <= 1'b0;
        end else if (timeout) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  assign s_addr   = req_q.addr;
  assign s_wen    = req_q.wen;
  assign s_wdata  = req_q.wdata;
  assign s_wmask  = req_q.wmask;
  assign m0_rdata = rdata_q;
  assign m1_rdata = rdata_q;
  assign m0_err   = err_q;
  assign m1_err   = err_q;

endmodule

// File: tb/tb_ysyx_23060187_mem_arbiter.sv
// Bench for ysyx_23060187_mem_arbiter: arbitration table, directed corner sequences,
// and random traffic checked against a transaction-level model.
module tb_ysyx_23060187_mem_arbiter;

  localparam int unsigned TO = 4;
  localparam int unsigned AW = 32;

  logic          clk;
  logic          rst;
  logic          m0_req_valid, m0_req_ready, m0_resp_valid, m0_resp_ready, m0_err;
  logic [AW-1:0] m0_addr;
  logic [31:0]   m0_rdata;
  logic          m1_req_valid, m1_req_ready, m1_wen, m1_resp_valid, m1_resp_ready, m1_err;
  logic [AW-1:0] m1_addr;
  logic [31:0]   m1_wdata, m1_rdata;
  logic [3:0]    m1_wmask;
  logic          s_req_valid, s_req_ready, s_wen, s_resp_valid, s_resp_ready;
  logic [AW-1:0] s_addr;
  logic [31:0]   s_wdata, s_rdata;
  logic [3:0]    s_wmask;

  int n_chk  = 0;
  int n_fail = 0;

  ysyx_23060187_mem_arbiter #(.TIMEOUT(TO), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr),
    .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m0_resp_ready),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_addr(m1_addr),
    .m1_wen(m1_wen), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m1_resp_ready),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_addr(s_addr),
    .s_wen(s_wen), .s_wdata(s_wdata), .s_wmask(s_wmask),
    .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready), .s_rdata(s_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic v0;
    logic v1;
    logic r0;
    logic r1;
  } arb_vec_t;

  arb_vec_t tbl [13];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hA5C3_3C5A;
  endfunction

  // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req_valid = 1'b0; m0_addr = '0; m0_resp_ready = 1'b0;
    m1_req_valid = 1'b0; m1_addr = '0; m1_wen = 1'b0; m1_wdata = '0; m1_wmask = '0;
    m1_resp_ready = 1'b0;
    s_req_ready = 1'b0; s_resp_valid = 1'b0; s_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    m0_req_valid = 1'b1;
    m1_req_valid = 1'b1;
    rst = 1'b0;
    #2;
    chk1("rst_m0_req_ready", m0_req_ready, 1'b0);
    chk1("rst_m1_req_ready", m1_req_ready, 1'b0);
    chk1("rst_s_req_valid", s_req_valid, 1'b0);
    chk1("rst_m0_resp_valid", m0_resp_valid, 1'b0);
    chk1("rst_m1_resp_valid", m1_resp_valid, 1'b0);
    chk1("rst_s_resp_ready", s_resp_ready, 1'b1);
    chk32("rst_s_addr", s_addr, 32'h0);
    chk32("rst_m0_rdata", m0_rdata, 32'h0);
    m0_req_valid = 1'b0;
    m1_req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Finishes an already-accepted transaction with a zero-latency slave.
  task automatic serve(input logic m, input logic [31:0] addr, input logic wen,
                       input logic [31:0] wdata, input logic [3:0] wmask,
                       input logic [31:0] rd);
    s_req_ready = 1'b1;
    #1;
    chk1("srv_s_req_valid", s_req_valid, 1'b1);
    chk32("srv_s_addr", s_addr, addr);
    chk1("srv_s_wen", s_wen, wen);
    chk32("srv_s_wdata", s_wdata, wdata);
    chk32("srv_s_wmask", 32'(s_wmask), 32'(wmask));
    chk1("srv_sreq_s_resp_ready", s_resp_ready, 1'b0);
    chk1("srv_busy_req_ready", m0_req_ready | m1_req_ready, 1'b0);
    nxt();
    s_req_ready = 1'b0;
    s_resp_valid = 1'b1;
    s_rdata = rd;
    #1;
    chk1("srv_wait_s_resp_ready", s_resp_ready, 1'b1);
    chk1("srv_wait_s_req_valid", s_req_valid, 1'b0);
    nxt();
    s_resp_valid = 1'b0;
    s_rdata = 32'h0;
    m0_resp_ready = 1'b1;
    m1_resp_ready = 1'b1;
    #1;
    chk1("srv_m0_resp_valid", m0_resp_valid, ~m);
    chk1("srv_m1_resp_valid", m1_resp_valid, m);
    chk32("srv_rdata", m ? m1_rdata : m0_rdata, rd);
    chk1("srv_err", m ? m1_err : m0_err, 1'b0);
    chk1("srv_mresp_s_resp_ready", s_resp_ready, 1'b0);
    nxt();
    m0_resp_ready = 1'b0;
    m1_resp_ready = 1'b0;
  endtask

  // Random-traffic reference state
  logic        p0, p1, w1, win, busy, issued, in_wait, mresp, cur_m, ref_last, exp_err, cur_wen;
  logic        sb_busy, sb_iss, sb_wait, sb_mresp;
  logic [31:0] a0, a1, d1, cur_addr, cur_wdata, exp_rd;
  logic [3:0]  k1, cur_wmask;
  int          widx, sdly;

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1};

    do_reset();

    // Single IFU fetch and its latency
    m0_req_valid = 1'b1; m0_addr = 32'h8000_0000;
    #1;
    chk1("t1_c0_m0_req_ready", m0_req_ready, 1'b1);
    chk1("t1_c0_m1_req_ready", m1_req_ready, 1'b0);
    chk1("t1_c0_s_req_valid", s_req_valid, 1'b0);
    nxt();
    m0_req_valid = 1'b0; s_req_ready = 1'b1;
    #1;
    chk1("t1_c1_s_req_valid", s_req_valid, 1'b1);
    chk32("t1_c1_s_addr", s_addr, 32'h8000_0000);
    chk1("t1_c1_s_wen", s_wen, 1'b0);
    chk32("t1_c1_s_wmask", 32'(s_wmask), 32'h0);
    chk1("t1_c1_m0_req_ready", m0_req_ready, 1'b0);
    nxt();
    s_req_ready = 1'b0; s_resp_valid = 1'b1; s_rdata = 32'h0000_0413;
    #1;
    chk1("t1_c2_s_resp_ready", s_resp_ready, 1'b1);
    chk1("t1_c2_m0_resp_valid", m0_resp_valid, 1'b0);
    nxt();
    s_resp_valid = 1'b0; s_rdata = 32'h0; m0_resp_ready = 1'b1;
    #1;
    chk1("t1_c3_m0_resp_valid", m0_resp_valid, 1'b1);
    chk1("t1_c3_m1_resp_valid", m1_resp_valid, 1'b0);
    chk32("t1_c3_m0_rdata", m0_rdata, 32'h0000_0413);
    chk1("t1_c3_m0_err", m0_err, 1'b0);
    nxt();
    m0_resp_ready = 1'b0;
    #1;
    chk1("t1_c4_m0_resp_valid", m0_resp_valid, 1'b0);
    chk1("t1_c4_s_resp_ready", s_resp_ready, 1'b1);
    nxt();

    // Simultaneous requests right after reset: m0 first, then the m1 store
    do_reset();
    m0_req_valid = 1'b1; m0_addr = 32'h8000_0004;
    m1_req_valid = 1'b1; m1_addr = 32'h8000_1000; m1_wen = 1'b1;
    m1_wdata = 32'hDEAD_BEEF; m1_wmask = 4'hF;
    #1;
    chk1("t2_first_m0_req_ready", m0_req_ready, 1'b1);
    chk1("t2_first_m1_req_ready", m1_req_ready, 1'b0);
    nxt();
    m0_req_valid = 1'b0;
    serve(1'b0, 32'h8000_0004, 1'b0, 32'h0, 4'h0, 32'h1111_2222);
    #1;
    chk1("t2_second_m1_req_ready", m1_req_ready, 1'b1);
    chk1("t2_second_m0_req_ready", m0_req_ready, 1'b0);
    nxt();
    m1_req_valid = 1'b0;
    serve(1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h3333_4444);

    // Arbitration table; requests stay asserted through each transaction
    do_reset();
    for (int i = 0; i < 13; i++) begin
      m0_req_valid = tbl[i].v0;
      m1_req_valid = tbl[i].v1;
      m0_addr  = 32'h1000_0000 + 32'(i * 4);
      m1_addr  = 32'h2000_0000 + 32'(i * 4);
      m1_wen   = 1'(i & 1);
      m1_wdata = 32'h5500_0000 + 32'(i);
      m1_wmask = 4'(i);
      #1;
      chk1("tbl_m0_req_ready", m0_req_ready, tbl[i].r0);
      chk1("tbl_m1_req_ready", m1_req_ready, tbl[i].r1);
      nxt();
      if (tbl[i].r0) begin
        serve(1'b0, m0_addr, 1'b0, 32'h0, 4'h0, 32'hA000_0000 + 32'(i));
      end else if (tbl[i].r1) begin
        serve(1'b1, m1_addr, m1_wen, m1_wdata, m1_wmask, 32'hB000_0000 + 32'(i));
      end
    end
    idle_inputs();

    // Hung slave: error response after TO WAIT_RESP cycles, late response dropped
    m1_req_valid = 1'b1; m1_addr = 32'h3000_0000; m1_wen = 1'b0;
    #1;
    chk1("t4_m1_req_ready", m1_req_ready, 1'b1);
    nxt();
    m1_req_valid = 1'b0; s_req_ready = 1'b1;
    #1;
    chk1("t4_s_req_valid", s_req_valid, 1'b1);
    nxt();
    s_req_ready = 1'b0;
    for (int k = 0; k < int'(TO); k++) begin
      #1;
      chk1("t4_wait_s_resp_ready", s_resp_ready, 1'b1);
      chk1("t4_wait_m1_resp_valid", m1_resp_valid, 1'b0);
      nxt();
    end
    #1;
    chk1("t4_to_m1_resp_valid", m1_resp_valid, 1'b1);
    chk1("t4_to_m1_err", m1_err, 1'b1);
    chk32("t4_to_m1_rdata", m1_rdata, 32'h0);
    chk1("t4_to_m0_resp_valid", m0_resp_valid, 1'b0);
    nxt();
    m1_resp_ready = 1'b1;
    #1;
    chk1("t4_to_hold_m1_resp_valid", m1_resp_valid, 1'b1);
    chk1("t4_to_hold_m1_err", m1_err, 1'b1);
    nxt();
    m1_resp_ready = 1'b0; s_resp_valid = 1'b1; s_rdata = 32'h0BAD_0BAD;
    #1;
    chk1("t4_late_s_resp_ready", s_resp_ready, 1'b1);
    chk1("t4_late_m1_resp_valid", m1_resp_valid, 1'b0);
    nxt();
    s_resp_valid = 1'b0; s_rdata = 32'h0;
    #1;
    chk1("t4_after_m1_resp_valid", m1_resp_valid, 1'b0);
    chk1("t4_after_m0_resp_valid", m0_resp_valid, 1'b0);
    chk1("t4_after_s_req_valid", s_req_valid, 1'b0);
    nxt();
    m0_req_valid = 1'b1; m0_addr = 32'h3000_0040;
    #1;
    chk1("t4_next_m0_req_ready", m0_req_ready, 1'b1);
    nxt();
    m0_req_valid = 1'b0;
    serve(1'b0, 32'h3000_0040, 1'b0, 32'h0, 4'h0, 32'h1234_5678);

    // Response on the last allowed WAIT_RESP cycle wins over the timeout
    m1_req_valid = 1'b1; m1_addr = 32'h3000_0080;
    #1;
    chk1("t4b_m1_req_ready", m1_req_ready, 1'b1);
    nxt();
    m1_req_valid = 1'b0; s_req_ready = 1'b1;
    nxt();
    s_req_ready = 1'b0;
    for (int k = 0; k < int'(TO) - 1; k++) nxt();
    s_resp_valid = 1'b1; s_rdata = 32'h7777_0001;
    #1;
    chk1("t4b_last_m1_resp_valid", m1_resp_valid, 1'b0);
    nxt();
    s_resp_valid = 1'b0; s_rdata = 32'h0; m1_resp_ready = 1'b1;
    #1;
    chk1("t4b_m1_resp_valid", m1_resp_valid, 1'b1);
    chk1("t4b_m1_err", m1_err, 1'b0);
    chk32("t4b_m1_rdata", m1_rdata, 32'h7777_0001);
    nxt();
    m1_resp_ready = 1'b0;

    // Long SREQ stall (no timeout there) and back-pressure in MRESP
    m1_req_valid = 1'b1; m1_addr = 32'h4000_0010; m1_wen = 1'b1;
    m1_wdata = 32'h1357_9BDF; m1_wmask = 4'b0101;
    #1;
    chk1("t5_m1_req_ready", m1_req_ready, 1'b1);
    nxt();
    m1_req_valid = 1'b0; m1_addr = 32'hFFFF_FFFF; m1_wdata = 32'h0; m1_wmask = 4'h0;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk1("t5_stall_s_req_valid", s_req_valid, 1'b1);
      chk32("t5_stall_s_addr", s_addr, 32'h4000_0010);
      chk32("t5_stall_s_wdata", s_wdata, 32'h1357_9BDF);
      chk32("t5_stall_s_wmask", 32'(s_wmask), 32'h5);
      chk1("t5_stall_s_resp_ready", s_resp_ready, 1'b0);
      nxt();
    end
    s_req_ready = 1'b1;
    #1;
    chk1("t5_s_req_valid", s_req_valid, 1'b1);
    nxt();
    s_req_ready = 1'b0; s_resp_valid = 1'b1; s_rdata = 32'hCAFE_F00D;
    nxt();
    s_resp_valid = 1'b0; s_rdata = 32'h0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk1("t5_bp_m1_resp_valid", m1_resp_valid, 1'b1);
      chk32("t5_bp_m1_rdata", m1_rdata, 32'hCAFE_F00D);
      chk1("t5_bp_m1_err", m1_err, 1'b0);
      nxt();
    end
    m1_resp_ready = 1'b1;
    #1;
    chk1("t5_ack_m1_resp_valid", m1_resp_valid, 1'b1);
    nxt();
    m1_resp_ready = 1'b0;
    #1;
    chk1("t5_idle_m1_resp_valid", m1_resp_valid, 1'b0);
    nxt();

    // Asynchronous reset while waiting for the slave
    idle_inputs();
    m0_req_valid = 1'b1; m0_addr = 32'h5000_0000;
    #1;
    chk1("t6_m0_req_ready", m0_req_ready, 1'b1);
    nxt();
    m0_req_valid = 1'b0; s_req_ready = 1'b1;
    nxt();
    s_req_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk1("t6_rst_s_req_valid", s_req_valid, 1'b0);
    chk1("t6_rst_m0_resp_valid", m0_resp_valid, 1'b0);
    chk1("t6_rst_m1_resp_valid", m1_resp_valid, 1'b0);
    chk32("t6_rst_s_addr", s_addr, 32'h0);
    chk32("t6_rst_m0_rdata", m0_rdata, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    m0_req_valid = 1'b1; m0_addr = 32'h5000_0100;
    m1_req_valid = 1'b1; m1_addr = 32'h5000_0200;
    #1;
    chk1("t6_post_s_resp_ready", s_resp_ready, 1'b1);
    chk1("t6_post_m0_req_ready", m0_req_ready, 1'b1);
    chk1("t6_post_m1_req_ready", m1_req_ready, 1'b0);
    nxt();
    m0_req_valid = 1'b0; m1_req_valid = 1'b0;
    serve(1'b0, 32'h5000_0100, 1'b0, 32'h0, 4'h0, 32'h0F0F_0F0F);

    // Random traffic against the transaction-level model
    do_reset();
    p0 = 1'b0; p1 = 1'b0; a0 = '0; a1 = '0; d1 = '0; w1 = 1'b0; k1 = '0;
    busy = 1'b0; issued = 1'b0; in_wait = 1'b0; mresp = 1'b0; cur_m = 1'b0;
    ref_last = 1'b1; widx = 0; sdly = 0; exp_rd = '0; exp_err = 1'b0;
    cur_addr = '0; cur_wen = 1'b0; cur_wdata = '0; cur_wmask = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!p0 && $urandom_range(0, 2) == 0) begin
        p0 = 1'b1; a0 = $urandom;
      end
      if (!p1 && $urandom_range(0, 2) == 0) begin
        p1 = 1'b1; a1 = $urandom; d1 = $urandom;
        w1 = 1'($urandom_range(0, 1)); k1 = 4'($urandom_range(0, 15));
      end
      m0_req_valid = p0; m0_addr = a0;
      m1_req_valid = p1; m1_addr = a1; m1_wen = w1; m1_wdata = d1; m1_wmask = k1;
      s_req_ready  = ($urandom_range(0, 3) != 0);
      s_resp_valid = in_wait && (widx == sdly);
      s_rdata      = s_resp_valid ? mem_data(cur_addr) : $urandom;
      m0_resp_ready = 1'($urandom_range(0, 1));
      m1_resp_ready = 1'($urandom_range(0, 1));
      #1;
      sb_busy = busy; sb_iss = issued; sb_wait = in_wait; sb_mresp = mresp;
      chk1("rnd_s_req_valid", s_req_valid, sb_busy && !sb_iss);
      chk1("rnd_s_resp_ready", s_resp_ready, !sb_busy || sb_wait);
      chk1("rnd_m0_resp_valid", m0_resp_valid, sb_mresp && !cur_m);
      chk1("rnd_m1_resp_valid", m1_resp_valid, sb_mresp && cur_m);
      if (!sb_busy) begin
        win = (p0 && p1) ? !ref_last : p1;
        chk1("rnd_m0_req_ready", m0_req_ready, (p0 || p1) && !win);
        chk1("rnd_m1_req_ready", m1_req_ready, (p0 || p1) && win);
        if (p0 || p1) begin
          busy = 1'b1; issued = 1'b0; cur_m = win; ref_last = win;
          if (win) begin
            cur_addr = a1; cur_wen = w1; cur_wdata = d1; cur_wmask = k1; p1 = 1'b0;
          end else begin
            cur_addr = a0; cur_wen = 1'b0; cur_wdata = '0; cur_wmask = '0; p0 = 1'b0;
          end
        end
      end else begin
        chk1("rnd_busy_req_ready", m0_req_ready | m1_req_ready, 1'b0);
      end
      if (sb_busy && !sb_iss && s_req_ready) begin
        chk32("rnd_s_addr", s_addr, cur_addr);
        chk1("rnd_s_wen", s_wen, cur_wen);
        chk32("rnd_s_wdata", s_wdata, cur_wdata);
        chk32("rnd_s_wmask", 32'(s_wmask), 32'(cur_wmask));
        issued = 1'b1; in_wait = 1'b1; widx = 0;
        sdly = int'($urandom_range(0, TO + 1));
      end
      if (sb_wait) begin
        if (s_resp_valid) begin
          in_wait = 1'b0; mresp = 1'b1; exp_rd = mem_data(cur_addr); exp_err = 1'b0;
        end else if (widx == int'(TO) - 1) begin
          in_wait = 1'b0; mresp = 1'b1; exp_rd = '0; exp_err = 1'b1;
        end else begin
          widx++;
        end
      end
      if (sb_mresp) begin
        chk32("rnd_rdata", cur_m ? m1_rdata : m0_rdata, exp_rd);
        chk1("rnd_err", cur_m ? m1_err : m0_err, exp_err);
        if (cur_m ? m1_resp_ready : m0_resp_ready) begin
          busy = 1'b0; issued = 1'b0; mresp = 1'b0;
        end
      end
      nxt();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
